program_loader: RTL and testbench
=================================

# program_loader

Writer-side companion to the instruction fetch stage: fills program memory before fetch begins. Accepts a byte stream over a valid/ready handshake and assembles little-endian 68-bit instruction words. Each word is written to consecutive program-memory addresses through the memory's write port (PM_wr / address / PM_inst_inp). When the load completes, the block pulses the PC write port with the load base address. It holds fetch off for the whole session.

## Interface
- ADDR_W, 5, program-memory address width (32 words)
- INST_W, 68, instruction width; bytes per word = ceil(INST_W/8) = 9
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  begin load session; sampled only in IDLE
- base_addr  input  5  first program-memory address; latched on start
- word_count  input  6  words to load, 0..32; latched on start
- byte_valid  input  1  byte_data valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- PM_wr  output  1  program-memory write strobe, one cycle per word
- PM_address  output  5  write address
- PM_inst_inp  output  68  write data
- PC_write  output  1  one-cycle PC load strobe
- PC_addressin  output  5  PC load value (= latched base_addr)
- fetch_hold  output  1  high while busy; gates fetch control signals low
- done  output  1  one-cycle completion pulse
- fmt_err  output  1  sticky format error, cleared on next accepted start

## Operation
- States: IDLE, COLLECT, WRITE, SETPC, DONE. All outputs are registered.
- IDLE:
  - When start=1, latch base_addr and word_count; set addr=base_addr, remaining=word_count, byte_idx=0, and clear fmt_err.
  - Go to DONE if word_count==0; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1. On byte_valid&&byte_ready, store the byte at word bits [8*byte_idx+7 : 8*byte_idx] and increment byte_idx.
  - Byte 8 supplies bits [67:64] from byte_data[3:0]. If byte_data[7:4]!=0 on byte 8, set fmt_err; the word is still written.
  - After byte 8 is accepted, go to WRITE.
- WRITE:
  - PM_wr=1, PM_address=addr, PM_inst_inp=assembled word.
  - addr increments modulo 32: 31 wraps to 0, and no error is raised on wrap. remaining decrements and byte_idx clears.
  - Go to SETPC if remaining reaches 0; otherwise go to COLLECT.
- SETPC: PC_write=1, PC_addressin=latched base. Next state is DONE.
- DONE: done=1. Next state is IDLE.
- fetch_hold=1 in every state except IDLE.
- start outside IDLE is ignored. word_count>32 saturates to 32.
- word_count==0: no PM_wr and no PC_write; only the done pulse is produced.

## Timing
- Reset (reset=0 at an edge):
  - State becomes IDLE; byte_ready, PM_wr, PC_write, fetch_hold, done and fmt_err all become 0.
  - PM_address, PM_inst_inp and PC_addressin become 0; addr, remaining and byte_idx become 0.
  - Reset mid-session discards any partial word. No further writes occur.
- Cycle 0 is the edge where start is sampled. In cycle 1 the state is COLLECT and byte_ready=1.
- A byte transfers on any edge where byte_valid=1 and byte_ready=1. Stalls (byte_valid=0) insert cycles without loss.
- Per word: at least 9 transfer cycles plus 1 WRITE cycle. byte_ready=0 during the WRITE cycle.
- N words with an unstalled stream:
  - PM_wr in cycles 10, 20, …, 10N.
  - PC_write in cycle 10N+1; done in cycle 10N+2; IDLE with fetch_hold=0 in cycle 10N+3.
- PM_wr, PC_write and done are each exactly one cycle wide and never coincide.

## Test plan
- Reset mid-load:
  - Stimulus: reset=0 for 1 cycle after 5 bytes of word 0.
  - Required: next cycle byte_ready=0, fetch_hold=0, no PM_wr. A new start with count=1 then writes only the fresh word.
- Single word:
  - Stimulus: base=3, count=1, bytes 0x01..0x08 then 0x0A.
  - Required: PM_wr in cycle 10 with PM_address=3 and PM_inst_inp=68'hA_0807060504030201. PC_write=1 with PC_addressin=3 in cycle 11. done in cycle 12.
- Wrap-around:
  - Stimulus: base=30, count=4.
  - Required: writes to addresses 30, 31, 0, 1; PC_addressin=30.
- Stalled stream:
  - Stimulus: byte_valid toggling 1/0 every cycle for count=2.
  - Required: write data identical to the unstalled case; PM_wr in cycles 18 and 36.
- Zero count:
  - Stimulus: start with count=0.
  - Required: done in cycle 1; no PM_wr and no PC_write. start asserted while busy is ignored.
- Format error:
  - Stimulus: byte 8 = 0xF5.
  - Required: the word is written with bits [67:64]=5 and fmt_err=1 stays high until the next start.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian instruction words, writes them to
// consecutive program-memory addresses, then loads the PC with the base address.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 68
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              PM_wr,
  output logic [ADDR_W-1:0] PM_address,
  output logic [INST_W-1:0] PM_inst_inp,
  output logic              PC_write,
  output logic [ADDR_W-1:0] PC_addressin,
  output logic              fetch_hold,
  output logic              done,
  output logic              fmt_err
);

  localparam int NBYTES   = (INST_W + 7) / 8;
  localparam int LAST_IDX = NBYTES - 1;
  localparam int LOW_W    = 8 * LAST_IDX;
  localparam int TOP_W    = INST_W - LOW_W;
  localparam int IDX_W    = $clog2(NBYTES);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, SETPC, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [IDX_W-1:0]  byte_idx;
  logic [LOW_W-1:0]  word_buf;
  logic              fire;
  logic              last_byte;

  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] wc);
    return (wc > DEPTH) ? DEPTH : wc;
  endfunction

  assign fire      = byte_valid && byte_ready;
  assign last_byte = (byte_idx == IDX_W'(LAST_IDX));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (sat_count(word_count) == '0) ? DONE : COLLECT;
      COLLECT: if (fire && last_byte) state_nx = WRITE;
      WRITE:   state_nx = (remaining == (ADDR_W+1)'(1)) ? SETPC : COLLECT;
      SETPC:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      base_q       <= '0;
      addr         <= '0;
      remaining    <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      byte_ready   <= 1'b0;
      PM_wr        <= 1'b0;
      PM_address   <= '0;
      PM_inst_inp  <= '0;
      PC_write     <= 1'b0;
      PC_addressin <= '0;
      fetch_hold   <= 1'b0;
      done         <= 1'b0;
      fmt_err      <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_ready <= (state_nx == COLLECT);
      PM_wr      <= (state_nx == WRITE);
      PC_write   <= (state_nx == SETPC);
      done       <= (state_nx == DONE);
      fetch_hold <= (state_nx != IDLE);
      case (state)
        IDLE: if (start) begin
          base_q    <= base_addr;
          addr      <= base_addr;
          remaining <= sat_count(word_count);
          byte_idx  <= '0;
          fmt_err   <= 1'b0;
        end
        COLLECT: if (fire) begin
          // The final byte only partly fits the word; its spare high bits flag a bad stream.
          if (last_byte) begin
            PM_address  <= addr;
            PM_inst_inp <= {byte_data[TOP_W-1:0], word_buf};
            if (byte_data[7:TOP_W] != '0) fmt_err <= 1'b1;
          end else begin
            word_buf[8*int'(byte_idx) +: 8] <= byte_data;
          end
          byte_idx <= byte_idx + 1'b1;
        end
        WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          byte_idx  <= '0;
        end
        default: ;
      endcase
      if (state_nx == SETPC) PC_addressin <= base_q;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a per-cycle expectation table is built from the
// session rules (byte counts, stalls, address wrap) and compared against the outputs.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        PM_wr;
  logic [4:0]  PM_address;
  logic [67:0] PM_inst_inp;
  logic        PC_write;
  logic [4:0]  PC_addressin;
  logic        fetch_hold;
  logic        done;
  logic        fmt_err;

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .PM_wr(PM_wr), .PM_address(PM_address),
    .PM_inst_inp(PM_inst_inp), .PC_write(PC_write), .PC_addressin(PC_addressin),
    .fetch_hold(fetch_hold), .done(done), .fmt_err(fmt_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stream [0:287];
  bit          vpat   [0:2047];
  bit          e_ready[0:2047];
  bit          e_wr   [0:2047];
  bit          e_pc   [0:2047];
  bit          e_done [0:2047];
  bit          e_hold [0:2047];
  logic [4:0]  e_addr [0:2047];
  logic [67:0] e_data [0:2047];
  logic [67:0] last_data;
  logic [4:0]  last_addr;
  int          wr_cyc[$];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] word_of(input int w);
    logic [67:0] r = '0;
    for (int b = 0; b < 9; b++) r = r | (68'(stream[w*9+b]) << (8*b));
    return r;
  endfunction

  task automatic fill_stream(input int fmt_pct);
    for (int i = 0; i < 288; i++) begin
      stream[i] = 8'($urandom);
      if (i % 9 == 8 && $urandom_range(0, 99) >= fmt_pct) stream[i][7:4] = 4'h0;
    end
  endtask

  // mode 0: continuous stream, 1: valid on odd cycles only, 2: random gaps
  task automatic run_session(input logic [4:0] base, input logic [5:0] cnt, input int mode);
    int  n, c, last, ptr;
    bit  exp_fmt, fire;
    n = (cnt > 32) ? 32 : int'(cnt);
    for (int i = 0; i < 2048; i++) begin
      vpat[i]    = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(i % 2) : ($urandom_range(0, 3) != 0);
      e_ready[i] = 0; e_wr[i] = 0; e_pc[i] = 0; e_done[i] = 0; e_hold[i] = 0;
      e_addr[i]  = '0; e_data[i] = '0;
    end
    c = 1;
    for (int w = 0; w < n; w++) begin
      int got = 0;
      while (got < 9 && c < 2000) begin
        e_ready[c] = 1; e_hold[c] = 1;
        if (vpat[c]) got++;
        c++;
      end
      e_wr[c] = 1; e_hold[c] = 1;
      e_addr[c] = 5'((int'(base) + w) % 32);
      e_data[c] = word_of(w);
      c++;
    end
    if (n > 0) begin e_pc[c] = 1; e_hold[c] = 1; c++; end
    e_done[c] = 1; e_hold[c] = 1; c++;
    last = c;
    exp_fmt = 0;
    for (int w = 0; w < n; w++) if (stream[w*9+8][7:4] != 4'h0) exp_fmt = 1;

    wr_cyc.delete();
    ptr = 0;
    start = 1'b1; base_addr = base; word_count = cnt; byte_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc <= last; cyc++) begin
      chk("byte_ready", byte_ready, e_ready[cyc]);
      chk("PM_wr", PM_wr, e_wr[cyc]);
      chk("PC_write", PC_write, e_pc[cyc]);
      chk("done", done, e_done[cyc]);
      chk("fetch_hold", fetch_hold, e_hold[cyc]);
      if (e_wr[cyc]) begin
        chk("PM_address", PM_address, e_addr[cyc]);
        chk("PM_inst_inp", PM_inst_inp, e_data[cyc]);
      end
      if (e_pc[cyc]) chk("PC_addressin", PC_addressin, base);
      if (cyc == 1) chk("fmt_clear", fmt_err, 1'b0);
      if (cyc == last) chk("fmt_err", fmt_err, exp_fmt);
      if (PM_wr === 1'b1) begin
        wr_cyc.push_back(cyc);
        last_data = PM_inst_inp;
        last_addr = PM_address;
      end
      start      = (cyc < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      base_addr  = 5'($urandom);
      word_count = 6'($urandom);
      byte_valid = (cyc < last) ? vpat[cyc] : 1'b0;
      byte_data  = (ptr < n*9) ? stream[ptr] : 8'($urandom);
      fire = byte_valid && byte_ready;
      @(posedge clk);
      if (fire) ptr++;
      @(negedge clk);
    end
    chk("bytes_used", 68'(ptr), 68'(n*9));
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_hold", fetch_hold, 1'b0);
    chk("rst_outs", {PM_wr, PC_write, done, fmt_err}, 4'b0);
    chk("rst_addr", PM_address, 5'd0);
    chk("rst_data", PM_inst_inp, 68'd0);
    chk("rst_pc", PC_addressin, 5'd0);
    reset = 1'b1;

    // single word with fixed bytes
    for (int i = 0; i < 8; i++) stream[i] = 8'(i + 1);
    stream[8] = 8'h0A;
    run_session(5'd3, 6'd1, 0);
    chk("sw_data", last_data, 68'hA_0807060504030201);
    chk("sw_addr", last_addr, 5'd3);
    chk("sw_cycle", 68'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 68'd10);

    // address wrap
    fill_stream(0);
    run_session(5'd30, 6'd4, 0);

    // stalled stream, write cycles 18 and 36
    fill_stream(0);
    run_session(5'd12, 6'd2, 1);
    chk("stall_n", 68'(wr_cyc.size()), 68'd2);
    if (wr_cyc.size() == 2) begin
      chk("stall_c0", 68'(wr_cyc[0]), 68'd18);
      chk("stall_c1", 68'(wr_cyc[1]), 68'd36);
    end

    // zero count
    run_session(5'd5, 6'd0, 0);
    chk("zero_nwr", 68'(wr_cyc.size()), 68'd0);

    // format error, sticky while idle
    fill_stream(0);
    stream[8] = 8'hF5;
    run_session(5'd8, 6'd1, 0);
    chk("fmt_top", 68'(last_data[67:64]), 68'd5);
    repeat (3) @(negedge clk);
    chk("fmt_sticky", fmt_err, 1'b1);

    // reset after 5 bytes of word 0
    fill_stream(0);
    start = 1'b1; base_addr = 5'd7; word_count = 6'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1; byte_data = stream[i];
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0; byte_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_ready", byte_ready, 1'b0);
    chk("mid_hold", fetch_hold, 1'b0);
    chk("mid_wr", PM_wr, 1'b0);
    chk("mid_fmt", fmt_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_idle_wr", PM_wr, 1'b0);
    end
    fill_stream(0);
    run_session(5'd9, 6'd1, 0);
    chk("fresh_n", 68'(wr_cyc.size()), 68'd1);

    // saturated count
    fill_stream(20);
    run_session(5'd17, 6'd40, 0);
    chk("sat_n", 68'(wr_cyc.size()), 68'd32);

    // random sessions
    for (int s = 0; s < 8; s++) begin
      fill_stream(25);
      run_session(5'($urandom), 6'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
